// File: rtl/fp_alu_responder.sv
// fp_alu_responder: request/response wrapper around a single-precision
// floating-point add/multiply ALU.
//  - stage 1 holds one accepted request and drives the ALU directly
//  - the ALU result is written into a DEPTH-entry response FIFO one edge later
//  - req_ready is credit based: (fifo_count + stage1_valid) < DEPTH
// Build option: define FP_ALU_RSP_FLAGS_EN to compute {nan, inf, zero, sign}
// at FIFO write and store them per entry; otherwise rsp_flags is 4'b0000.
//
// fp_alu: combinational IEEE-754 single add/multiply.
//  - round to nearest even; denormal inputs and results flush to signed zero
//  - any NaN result is the canonical quiet NaN 0x7FC00000
//  - o_carry flags significand overflow in the general path (sum or product
//    reached 2.0 and needed a one-bit right normalisation)

module fp_alu (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_sel,
   output logic [31:0] o_result,
   output logic        o_carry
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   logic        w_sa, w_sb;
   logic [7:0]  w_ea, w_eb;
   logic [22:0] w_fa, w_fb;
   logic [23:0] w_ma, w_mb;
   logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;

   assign w_sa     = i_a[31];
   assign w_sb     = i_b[31];
   assign w_ea     = i_a[30:23];
   assign w_eb     = i_b[30:23];
   assign w_fa     = i_a[22:0];
   assign w_fb     = i_b[22:0];
   assign w_ma     = {1'b1, w_fa};
   assign w_mb     = {1'b1, w_fb};
   assign w_a_nan  = (w_ea == 8'hFF) && (w_fa != 23'd0);
   assign w_b_nan  = (w_eb == 8'hFF) && (w_fb != 23'd0);
   assign w_a_inf  = (w_ea == 8'hFF) && (w_fa == 23'd0);
   assign w_b_inf  = (w_eb == 8'hFF) && (w_fb == 23'd0);
   assign w_a_zero = (w_ea == 8'h00);
   assign w_b_zero = (w_eb == 8'h00);

   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      n = 5'd27;
      for (int i = 0; i <= 26; i++) begin
         if (v[i]) n = 5'(26 - i);
      end
      return n;
   endfunction

   // add path: align smaller magnitude, add or subtract, normalise
   logic        w_swap, w_big_s, w_sml_s, w_eff_sub;
   logic [7:0]  w_big_e, w_sml_e, w_diff_e;
   logic [23:0] w_big_m, w_sml_m;
   logic [26:0] w_big_x, w_sml_x, w_sml_sh, w_dif;
   logic [27:0] w_sum;
   logic [4:0]  w_lz;
   logic [26:0] w_add_man;
   logic [9:0]  w_add_exp;
   logic        w_add_carry, w_add_cancel;

   // add-path alignment and normalisation
   always_comb begin
      w_swap       = (i_b[30:0] > i_a[30:0]);
      w_big_s      = w_swap ? w_sb : w_sa;
      w_sml_s      = w_swap ? w_sa : w_sb;
      w_big_e      = w_swap ? w_eb : w_ea;
      w_sml_e      = w_swap ? w_ea : w_eb;
      w_big_m      = w_swap ? w_mb : w_ma;
      w_sml_m      = w_swap ? w_ma : w_mb;
      w_eff_sub    = (w_big_s != w_sml_s);
      w_diff_e     = w_big_e - w_sml_e;
      w_big_x      = {w_big_m, 3'b000};
      w_sml_x      = {w_sml_m, 3'b000};
      w_sml_sh     = 27'd1;
      w_sum        = 28'd0;
      w_dif        = 27'd0;
      w_lz         = 5'd0;
      w_add_man    = 27'd0;
      w_add_exp    = 10'd0;
      w_add_carry  = 1'b0;
      w_add_cancel = 1'b0;
      if (w_diff_e < 8'd27) begin
         w_sml_sh    = w_sml_x >> w_diff_e;
         w_sml_sh[0] = w_sml_sh[0] | (|(w_sml_x & ~({27{1'b1}} << w_diff_e)));
      end
      if (!w_eff_sub) begin
         w_sum = {1'b0, w_big_x} + {1'b0, w_sml_sh};
         if (w_sum[27]) begin
            w_add_man   = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_add_exp   = {2'b00, w_big_e} + 10'd1;
            w_add_carry = 1'b1;
         end else begin
            w_add_man = w_sum[26:0];
            w_add_exp = {2'b00, w_big_e};
         end
      end else begin
         w_dif        = w_big_x - w_sml_sh;
         w_add_cancel = (w_dif == 27'd0);
         w_lz         = lzc27(w_dif);
         w_add_man    = w_dif << w_lz;
         w_add_exp    = {2'b00, w_big_e} - {5'd0, w_lz};
      end
   end

   // multiply path
   logic [47:0] w_prod;
   logic [9:0]  w_mul_exp0, w_mul_exp;
   logic [26:0] w_mul_man;
   logic        w_mul_carry;

   assign w_prod      = w_ma * w_mb;
   assign w_mul_exp0  = ({2'b00, w_ea} + {2'b00, w_eb}) - 10'd127;
   assign w_mul_carry = w_prod[47];
   assign w_mul_exp   = w_mul_exp0 + {9'd0, w_prod[47]};
   assign w_mul_man   = w_prod[47] ? {w_prod[47:22], |w_prod[21:0]}
                                   : {w_prod[46:21], |w_prod[20:0]};

   // shared round-to-nearest-even and pack
   logic        w_sign;
   logic [26:0] w_man;
   logic [9:0]  w_exp, w_fin_e;
   logic        w_rnd_up;
   logic [24:0] w_mant25;
   logic [22:0] w_fin_f;
   logic [31:0] w_general;

   assign w_sign   = i_sel ? (w_sa ^ w_sb) : w_big_s;
   assign w_man    = i_sel ? w_mul_man : w_add_man;
   assign w_exp    = i_sel ? w_mul_exp : w_add_exp;
   assign w_rnd_up = w_man[2] & (w_man[1] | w_man[0] | w_man[3]);
   assign w_mant25 = {1'b0, w_man[26:3]} + {24'd0, w_rnd_up};
   assign w_fin_e  = w_exp + {9'd0, w_mant25[24]};
   assign w_fin_f  = w_mant25[24] ? w_mant25[23:1] : w_mant25[22:0];

   // general-path packing with overflow to infinity and underflow to zero
   always_comb begin
      if (w_fin_e[9] || (w_fin_e == 10'd0))
         w_general = {w_sign, 31'd0};
      else if (w_fin_e >= 10'd255)
         w_general = {w_sign, 8'hFF, 23'd0};
      else
         w_general = {w_sign, w_fin_e[7:0], w_fin_f};
   end

   // special operand handling ahead of the general path
   always_comb begin
      o_result = w_general;
      o_carry  = 1'b0;
      if (i_sel) begin
         if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
            o_result = QNAN;
         else if (w_a_inf || w_b_inf)
            o_result = {w_sa ^ w_sb, 8'hFF, 23'd0};
         else if (w_a_zero || w_b_zero)
            o_result = {w_sa ^ w_sb, 31'd0};
         else
            o_carry = w_mul_carry;
      end else begin
         if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf && (w_sa != w_sb)))
            o_result = QNAN;
         else if (w_a_inf)
            o_result = {w_sa, 8'hFF, 23'd0};
         else if (w_b_inf)
            o_result = {w_sb, 8'hFF, 23'd0};
         else if (w_a_zero && w_b_zero)
            o_result = {w_sa & w_sb, 31'd0};
         else if (w_a_zero)
            o_result = i_b;
         else if (w_b_zero)
            o_result = i_a;
         else if (w_eff_sub && w_add_cancel)
            o_result = 32'd0;
         else
            o_carry = w_add_carry;
      end
   end

endmodule

module fp_alu_responder #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [31:0]      req_a,
   input  logic [31:0]      req_b,
   input  logic             req_sel,
   input  logic [TAG_W-1:0] req_tag,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_result,
   output logic             rsp_carry,
   output logic [TAG_W-1:0] rsp_tag,
   output logic [3:0]       rsp_flags
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]   DEPTH_L = DEPTH[CNT_W:0];
   localparam logic [PTR_W-1:0] LAST_L  = PTR_W'(DEPTH - 1);

   logic             r_s1_valid;
   logic [31:0]      r_s1_a, r_s1_b;
   logic             r_s1_sel;
   logic [TAG_W-1:0] r_s1_tag;

   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;

   logic [31:0]      r_mem_result [DEPTH];
   logic             r_mem_carry  [DEPTH];
   logic [TAG_W-1:0] r_mem_tag    [DEPTH];

   logic [31:0]      w_alu_result;
   logic             w_alu_carry;
   logic [CNT_W:0]   w_occ;
   logic             w_accept, w_push, w_pop;

   fp_alu u_alu (
      .i_a      (r_s1_a),
      .i_b      (r_s1_b),
      .i_sel    (r_s1_sel),
      .o_result (w_alu_result),
      .o_carry  (w_alu_carry)
   );

   // Stage 1 always drains into the FIFO on the following edge; the credit
   // check on req_ready guarantees there is room for it.
   assign w_occ     = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
   assign req_ready = !rst && (w_occ < DEPTH_L);
   assign w_accept  = req_valid && req_ready;
   assign w_push    = r_s1_valid;
   assign w_pop     = rsp_valid && rsp_ready;

   // stage-1 request capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_a     <= 32'd0;
         r_s1_b     <= 32'd0;
         r_s1_sel   <= 1'b0;
         r_s1_tag   <= '0;
      end else begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_a   <= req_a;
            r_s1_b   <= req_b;
            r_s1_sel <= req_sel;
            r_s1_tag <= req_tag;
         end
      end
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count  <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push)
            r_wr_ptr <= (r_wr_ptr == LAST_L) ? '0 : r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= (r_rd_ptr == LAST_L) ? '0 : r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

`ifdef FP_ALU_RSP_FLAGS_EN
   logic [3:0] r_mem_flags [DEPTH];
   logic [3:0] w_flags_in;

   assign w_flags_in = {(w_alu_result[30:23] == 8'hFF) && (w_alu_result[22:0] != 23'd0),
                        (w_alu_result[30:23] == 8'hFF) && (w_alu_result[22:0] == 23'd0),
                        (w_alu_result[30:23] == 8'h00) && (w_alu_result[22:0] == 23'd0),
                        w_alu_result[31]};
`endif

   // FIFO storage; contents are only visible through the valid-gated outputs
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_result[r_wr_ptr] <= w_alu_result;
         r_mem_carry[r_wr_ptr]  <= w_alu_carry;
         r_mem_tag[r_wr_ptr]    <= r_s1_tag;
`ifdef FP_ALU_RSP_FLAGS_EN
         r_mem_flags[r_wr_ptr]  <= w_flags_in;
`endif
      end
   end

   assign rsp_valid  = (r_count != '0);
   assign rsp_result = rsp_valid ? r_mem_result[r_rd_ptr] : 32'd0;
   assign rsp_carry  = rsp_valid ? r_mem_carry[r_rd_ptr]  : 1'b0;
   assign rsp_tag    = rsp_valid ? r_mem_tag[r_rd_ptr]    : '0;
`ifdef FP_ALU_RSP_FLAGS_EN
   assign rsp_flags  = rsp_valid ? r_mem_flags[r_rd_ptr]  : 4'b0000;
`else
   assign rsp_flags  = 4'b0000;
`endif

endmodule

// File: tb/tb_fp_alu_responder.sv
// Scoreboard bench for fp_alu_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares every accepted response and checks
// that a stalled response holds stable.
module tb_fp_alu_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_sel;
   logic [31:0] req_a, req_b;
   logic [3:0]  req_tag;
   logic        rsp_valid, rsp_ready, rsp_carry;
   logic [31:0] rsp_result;
   logic [3:0]  rsp_tag, rsp_flags;

   fp_alu_responder #(.DEPTH(4), .TAG_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_sel    (req_sel),
      .req_tag    (req_tag),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_result (rsp_result),
      .rsp_carry  (rsp_carry),
      .rsp_tag    (rsp_tag),
      .rsp_flags  (rsp_flags)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] res;
      logic [3:0]  tag;
      logic [3:0]  flg;
   } exp_t;

   exp_t sb_q[$];
   int   checks   = 0;
   int   failures = 0;

   function automatic logic [3:0] fexp(input logic [3:0] f);
`ifdef FP_ALU_RSP_FLAGS_EN
      return f;
`else
      return f & 4'b0000;
`endif
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // monitor: compare accepted responses in order, and hold stability
   logic        hold_v = 1'b0;
   logic [40:0] hold_snap;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         hold_v = 1'b0;
      end else begin
         if (hold_v)
            chk("hold_stable", {23'd0, rsp_valid, rsp_tag, rsp_flags, rsp_result}, {23'd0, hold_snap});
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_rsp actual_tag=%0d actual_result=%h required=no response", rsp_tag, rsp_result);
            end else begin
               e = sb_q.pop_front();
               chk("rsp_result", rsp_result, e.res);
               chk("rsp_tag", rsp_tag, e.tag);
               chk("rsp_flags", rsp_flags, e.flg);
            end
         end
         hold_v    = rsp_valid && !rsp_ready;
         hold_snap = {rsp_valid, rsp_tag, rsp_flags, rsp_result};
      end
   end

   task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sel,
                       input logic [3:0] tag, input logic [31:0] res, input logic [3:0] flg,
                       output int stall);
      exp_t e;
      stall     = 0;
      req_valid = 1'b1;
      req_a     = a;
      req_b     = b;
      req_sel   = sel;
      req_tag   = tag;
      @(negedge clk);
      while (!req_ready && stall < 200) begin
         @(negedge clk);
         stall++;
      end
      if (!req_ready) begin
         checks++;
         failures++;
         $display("FAIL send_timeout tag=%0d actual=not accepted required=accepted", tag);
      end else begin
         e.res = res;
         e.tag = tag;
         e.flg = fexp(flg);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((sb_q.size() != 0 || rsp_valid) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(name, sb_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // directed vectors: a, b, sel, expected result, expected {nan,inf,zero,sign}
   logic [31:0] va [10] = '{32'h3F800000, 32'h7F800000, 32'h3F800000, 32'h3FC00000, 32'h40400000,
                            32'h40000000, 32'h3F800000, 32'h7FC00000, 32'h7F800000, 32'hFF800000};
   logic [31:0] vb [10] = '{32'hBF800000, 32'h7F800000, 32'h00000000, 32'h3FC00000, 32'hBF800000,
                            32'h40400000, 32'hBF800000, 32'h3F800000, 32'hFF800000, 32'h3F800000};
   logic        vs [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
   logic [31:0] vr [10] = '{32'hBF800000, 32'h7F800000, 32'h00000000, 32'h40400000, 32'h40000000,
                            32'h40C00000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000};
   logic [3:0]  vf [10] = '{4'b0001, 4'b0100, 4'b0010, 4'b0000, 4'b0000,
                            4'b0000, 4'b0010, 4'b1000, 4'b1000, 4'b0101};

   // backpressure vectors: 1.0 + k for k = 0..5
   logic [31:0] bp_b [6] = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
   logic [31:0] bp_r [6] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000, 32'h40C00000};

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   st;
      int   tot_stall;
      int   acc;
      exp_t e;

      rst       = 1'b1;
      req_valid = 1'b0;
      req_a     = 32'd0;
      req_b     = 32'd0;
      req_sel   = 1'b0;
      req_tag   = 4'd0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_result", rsp_result, 0);
      chk("rst_rsp_tag", rsp_tag, 0);
      chk("rst_rsp_flags", rsp_flags, 0);
      rst = 1'b0;
      #1;
      chk("post_rst_req_ready", req_ready, 1);
      @(posedge clk);
      #1;

      // 1.0 + 2.0 with latency 2
      send(32'h3F800000, 32'h40000000, 1'b0, 4'd1, 32'h40400000, 4'b0000, st);
      chk("lat_after_accept_valid", rsp_valid, 0);
      @(posedge clk);
      #1;
      chk("lat_second_edge_valid", rsp_valid, 1);
      chk("lat_second_edge_tag", rsp_tag, 1);
      wait_drain("drain_first");

      // back-to-back directed vectors with rsp_ready high
      tot_stall = 0;
      for (int i = 0; i < 10; i++) begin
         send(va[i], vb[i], vs[i], 4'(i + 2), vr[i], vf[i], st);
         tot_stall += st;
      end
      chk("b2b_stall_cycles", tot_stall, 0);
      wait_drain("drain_vectors");

      // backpressure: six offered, four accepted
      rsp_ready = 1'b0;
      acc       = 0;
      for (int c = 0; c < 6; c++) begin
         req_valid = 1'b1;
         req_a     = 32'h3F800000;
         req_b     = bp_b[acc];
         req_sel   = 1'b0;
         req_tag   = acc[3:0];
         @(negedge clk);
         if (req_ready) begin
            e.res = bp_r[acc];
            e.tag = acc[3:0];
            e.flg = fexp(4'b0000);
            sb_q.push_back(e);
            acc++;
         end
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      chk("bp_accepted", acc, 4);
      chk("bp_req_ready_low", req_ready, 0);
      chk("bp_head_tag", rsp_tag, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("bp_still_full", req_ready, 0);
      rsp_ready = 1'b1;
      send(32'h3F800000, bp_b[4], 1'b0, 4'd4, bp_r[4], 4'b0000, st);
      chk("bp_credit_tag4_stall", st, 1);
      send(32'h3F800000, bp_b[5], 1'b0, 4'd5, bp_r[5], 4'b0000, st);
      chk("bp_credit_tag5_stall", st, 0);
      wait_drain("drain_backpressure");

      // reset with three queued and one in stage 1
      rsp_ready = 1'b0;
      for (int i = 0; i < 4; i++)
         send(32'h3F800000, 32'h40000000, 1'b0, 4'(8 + i), 32'h40400000, 4'b0000, st);
      chk("pre_rst_rsp_valid", rsp_valid, 1);
      rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", rsp_valid, 0);
      chk("midrst_req_ready", req_ready, 0);
      chk("midrst_rsp_tag", rsp_tag, 0);
      sb_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst       = 1'b0;
      rsp_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_stale_rsp", rsp_valid, 0);
      end
      @(posedge clk);
      #1;
      send(32'h3F800000, 32'hBF800000, 1'b1, 4'd12, 32'hBF800000, 4'b0001, st);
      chk("postrst_lat_accept_valid", rsp_valid, 0);
      @(posedge clk);
      #1;
      chk("postrst_lat_valid", rsp_valid, 1);
      chk("postrst_lat_tag", rsp_tag, 12);
      wait_drain("drain_final");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
